// File: rtl/jcpu_pkg.sv
// Shared types for the jcpu step sequencer: machine-cycle phase and sequencer
// state enums, plus the phase successor helper.
package jcpu_pkg;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_e;

  // PH3 wraps back to PH0.
  function automatic phase_e phase_next(input phase_e ph);
    return phase_e'(ph + 2'd1);
  endfunction

endpackage

// File: rtl/jstepseq_if.sv
// Control and machine-clock bundle of the step sequencer. The master side
// drives the control levels/pulses; the slave side is the sequencer.
interface jstepseq_if #(
  parameter int NSTEPS = 6,
  parameter int SW     = $clog2(NSTEPS)
) ();

  logic              run;
  logic              step_req;
  logic              halt;
  logic              done;
  logic              wclk;
  logic              wclkd;
  logic              wclke;
  logic              wclks;
  logic [NSTEPS-1:0] bos;
  logic [SW-1:0]     stepno;
  logic              halted;
  logic              cyc_end;

  modport master (
    output run, step_req, halt, done,
    input  wclk, wclkd, wclke, wclks, bos, stepno, halted, cyc_end
  );

  modport slave (
    input  run, step_req, halt, done,
    output wclk, wclkd, wclke, wclks, bos, stepno, halted, cyc_end
  );

endinterface

// File: rtl/jstepseq_phasegen.sv
// Four-phase machine clock generator: a 2-bit phase counter that can be held,
// with the wclk/wclkd/wclke/wclks and cyc_end decodes taken from the register.
module jphasegen
  import jcpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   hold,
  output phase_e ph,
  output logic   wclk,
  output logic   wclkd,
  output logic   wclke,
  output logic   wclks,
  output logic   cyc_end
);

  phase_e ph_q;
  phase_e ph_d;

  always_comb begin
    ph_d = hold ? ph_q : phase_next(ph_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_q <= PH0;
    end else begin
      ph_q <= ph_d;
    end
  end

  // Decodes come straight off the phase flop, so async reset reaches them at once.
  always_comb begin
    wclk    = (ph_q == PH0) || (ph_q == PH1);
    wclkd   = (ph_q == PH1) || (ph_q == PH2);
    wclke   = wclk | wclkd;
    wclks   = wclk & wclkd;
    cyc_end = (ph_q == PH3);
  end

  assign ph = ph_q;

endmodule

// File: rtl/jstepseq.sv
// One-hot instruction step sequencer: owns the step register, the RUN/WAIT/HALT
// state and the single-step request flag; phases come from jphasegen.
module jstepseq
  import jcpu_pkg::*;
#(
  parameter int NSTEPS = 6,
  parameter int SW     = $clog2(NSTEPS)
) (
  input  logic       clk,
  input  logic       reset,
  jstepseq_if.slave  bus
);

  localparam logic [SW-1:0]     LAST_STEP = SW'(NSTEPS - 1);
  localparam logic [NSTEPS-1:0] FIRST_BOS = NSTEPS'(1);

  state_e            state_q, state_d;
  logic [NSTEPS-1:0] bos_q, bos_d;
  logic [SW-1:0]     stepno_q, stepno_d;
  logic              pend_q, pend_d;

  phase_e ph;
  logic   hold;
  logic   start;
  logic   step_acc;
  logic   wclk, wclkd, wclke, wclks, cyc_end;

  jphasegen u_phasegen (
    .clk     (clk),
    .reset   (reset),
    .hold    (hold),
    .ph      (ph),
    .wclk    (wclk),
    .wclkd   (wclkd),
    .wclke   (wclke),
    .wclks   (wclks),
    .cyc_end (cyc_end)
  );

  // PH0 is the only point where a new machine cycle may begin; both the
  // post-reset hold and WAIT are simply "PH0 without a reason to start".
  always_comb begin
    start    = (ph == PH0) && (state_q != HALT) && (bus.run || pend_q);
    hold     = (ph == PH0) && !start;
    step_acc = bus.step_req && (state_q != HALT) && !((state_q == RUN) && bus.run);

    state_d  = state_q;
    bos_d    = bos_q;
    stepno_d = stepno_q;
    pend_d   = start ? 1'b0 : (pend_q | step_acc);

    if (state_q != HALT) begin
      if (ph == PH0) begin
        state_d = start ? RUN : WAIT;
      end else if (ph == PH3) begin
        // halt outranks done, done outranks the normal advance/wrap
        if (bus.halt) begin
          state_d  = HALT;
          bos_d    = '0;
          stepno_d = '0;
        end else begin
          state_d = bus.run ? RUN : WAIT;
          if (bus.done || (stepno_q == LAST_STEP)) begin
            bos_d    = FIRST_BOS;
            stepno_d = '0;
          end else begin
            bos_d    = {bos_q[NSTEPS-2:0], 1'b0};
            stepno_d = stepno_q + SW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      bos_q    <= FIRST_BOS;
      stepno_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bos_q    <= bos_d;
      stepno_q <= stepno_d;
      pend_q   <= pend_d;
    end
  end

  assign bus.wclk    = wclk;
  assign bus.wclkd   = wclkd;
  assign bus.wclke   = wclke;
  assign bus.wclks   = wclks;
  assign bus.cyc_end = cyc_end;
  assign bus.bos     = bos_q;
  assign bus.stepno  = stepno_q;
  assign bus.halted  = (state_q == HALT);

endmodule

// File: tb/tb_jstepseq.sv
// Randomized bench for jstepseq against a step-index/phase-count reference
// model (NSTEPS=6), plus a free-running NSTEPS=16 build.
module tb_jstepseq;

  logic clk = 1'b0;
  logic rst_n;
  logic rst16_n;

  always #5 clk = ~clk;

  jstepseq_if #(.NSTEPS(6))  bus6 ();
  jstepseq_if #(.NSTEPS(16)) bus16 ();

  jstepseq #(.NSTEPS(6)) dut6 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus6)
  );

  jstepseq #(.NSTEPS(16)) dut16 (
    .clk   (clk),
    .reset (rst16_n),
    .bus   (bus16)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: phase number, step index, and mode flags
  int m_ph;
  int m_step;
  bit m_halted;
  bit m_pend;
  bit m_wait;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph     = 0;
    m_step   = 0;
    m_halted = 1'b0;
    m_pend   = 1'b0;
    m_wait   = 1'b0;
  endtask

  // One clk edge of the sequencer, using the inputs present at that edge.
  task automatic model_clock();
    bit acc;
    if (m_halted) return;
    acc = bus6.step_req && !(!m_wait && bus6.run);
    if (m_ph == 0) begin
      if (bus6.run || m_pend) begin
        m_ph   = 1;
        m_wait = 1'b0;
        m_pend = 1'b0;
      end else begin
        m_wait = 1'b1;
        m_pend = m_pend | acc;
      end
    end else if (m_ph == 3) begin
      m_ph   = 0;
      m_pend = m_pend | acc;
      if (bus6.halt) begin
        m_halted = 1'b1;
      end else begin
        m_step = bus6.done ? 0 : (m_step + 1) % 6;
        m_wait = !bus6.run;
      end
    end else begin
      m_ph++;
      m_pend = m_pend | acc;
    end
  endtask

  task automatic check_outputs(input string where);
    logic [31:0] e_bos;
    e_bos = m_halted ? 32'd0 : (32'd1 << m_step);
    check_eq({where, ".bos"},     32'(bus6.bos),     e_bos);
    check_eq({where, ".stepno"},  32'(bus6.stepno),  m_halted ? 32'd0 : 32'(m_step));
    check_eq({where, ".wclk"},    32'(bus6.wclk),    32'(m_ph < 2));
    check_eq({where, ".wclkd"},   32'(bus6.wclkd),   32'(m_ph == 1 || m_ph == 2));
    check_eq({where, ".wclke"},   32'(bus6.wclke),   32'(m_ph != 3));
    check_eq({where, ".wclks"},   32'(bus6.wclks),   32'(m_ph == 1));
    check_eq({where, ".cyc_end"}, 32'(bus6.cyc_end), 32'(m_ph == 3));
    check_eq({where, ".halted"},  32'(bus6.halted),  32'(m_halted));
  endtask

  task automatic drive_random(input int mode, input bit allow_halt);
    case (mode)
      0:       bus6.run = ($urandom_range(99, 0) < 95);
      1:       bus6.run = ($urandom_range(99, 0) < 10);
      default: if ($urandom_range(9, 0) == 0) bus6.run = !bus6.run;
    endcase
    bus6.step_req = ($urandom_range(4, 0) == 0);
    bus6.done     = ($urandom_range(7, 0) == 0);
    bus6.halt     = allow_halt && ($urandom_range(59, 0) == 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    rst16_n       = 1'b0;
    bus6.run      = 1'b1;
    bus6.step_req = 1'b0;
    bus6.halt     = 1'b0;
    bus6.done     = 1'b0;
    bus16.run      = 1'b1;
    bus16.step_req = 1'b0;
    bus16.halt     = 1'b0;
    bus16.done     = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    check_eq("reset16.bos", 32'(bus16.bos), 32'd1);

    for (int seg = 0; seg < 12; seg++) begin
      @(negedge clk);
      rst_n = 1'b1;
      bus6.run = (seg % 4 != 1);
      for (int cyc = 0; cyc < 150; cyc++) begin
        check_outputs("run");
        drive_random(seg % 3, (seg % 4 == 3));
        @(posedge clk);
        model_clock();
        @(negedge clk);
      end
      // asynchronous reset away from any clock edge
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst");
    end

    // NSTEPS=16 free-running build
    @(negedge clk);
    rst16_n = 1'b1;
    for (int c = 0; c < 16 * 4 * 2 + 8; c++) begin
      check_eq("n16.stepno",  32'(bus16.stepno),  32'((c / 4) % 16));
      check_eq("n16.bos",     32'(bus16.bos),     32'd1 << ((c / 4) % 16));
      check_eq("n16.cyc_end", 32'(bus16.cyc_end), 32'(c % 4 == 3));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
